// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: widths, FSM encoding, opcodes and NZCV flag layout.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_NOT = 3'd7
    } op_t;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-facing bus of the ALU arbiter: two request ports plus the shared response signals.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic              Req0;
    logic [DATA_W-1:0] A0;
    logic [DATA_W-1:0] B0;
    logic [OP_W-1:0]   OP_Code0;
    logic              Req1;
    logic [DATA_W-1:0] A1;
    logic [DATA_W-1:0] B1;
    logic [OP_W-1:0]   OP_Code1;
    logic              Done0;
    logic              Done1;
    logic [DATA_W-1:0] Result;
    logic [3:0]        NZCV;
    logic              Grant;
    logic              Busy;

    modport master (
        output Req0, A0, B0, OP_Code0, Req1, A1, B1, OP_Code1,
        input  Done0, Done1, Result, NZCV, Grant, Busy
    );

    modport slave (
        input  Req0, A0, B0, OP_Code0, Req1, A1, B1, OP_Code1,
        output Done0, Done1, Result, NZCV, Grant, Busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-opcode ALU; C is carry-out for ADD and not-borrow for SUB, shifted-out bit for shifts.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
    output logic [DATA_W-1:0] o_result,
    output logic [3:0]        o_nzcv
);

    logic [DATA_W:0]   w_wide;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_wide = '0;
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (op_t'(i_op))
            OP_ADD: begin
                w_wide = {1'b0, i_a} + {1'b0, i_b};
                w_res  = w_wide[DATA_W-1:0];
                w_c    = w_wide[DATA_W];
                w_v    = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_res[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_SUB: begin
                w_wide = {1'b0, i_a} + {1'b0, ~i_b} + (DATA_W+1)'(1);
                w_res  = w_wide[DATA_W-1:0];
                w_c    = w_wide[DATA_W];
                w_v    = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_res[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_SHL: begin
                w_res = {i_a[DATA_W-2:0], 1'b0};
                w_c   = i_a[DATA_W-1];
            end
            OP_SHR: begin
                w_res = {1'b0, i_a[DATA_W-1:1]};
                w_c   = i_a[0];
            end
            OP_NOT: w_res = ~i_a;
            default: w_res = '0;
        endcase
    end

    assign o_result = w_res;
    assign o_nzcv   = pack_nzcv(w_res[DATA_W-1], (w_res == '0), w_c, w_v);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU: IDLE -> EXEC -> RESP, one op per 3 cycles.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_next;
    logic              w_load;
    logic              w_grant_sel;
    logic              r_grant;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_nzcv;
    logic [DATA_W-1:0] w_alu_result;
    logic [3:0]        w_alu_nzcv;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_grant_sel = ~bus.Req0;
`else
    logic r_prio;  // index of the requester that wins the next tie

    always_comb begin
        if (bus.Req0 && bus.Req1)
            w_grant_sel = r_prio;
        else
            w_grant_sel = bus.Req1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_prio <= 1'b0;
        else if (w_load)
            r_prio <= ~w_grant_sel;
    end
`endif

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    w_next = ST_EXEC;
                    w_load = 1'b1;
                end
            end
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_nzcv   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_grant <= w_grant_sel;
                r_a     <= w_grant_sel ? bus.A1 : bus.A0;
                r_b     <= w_grant_sel ? bus.B1 : bus.B0;
                r_op    <= w_grant_sel ? bus.OP_Code1 : bus.OP_Code0;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_alu_result;
                r_nzcv   <= w_alu_nzcv;
            end
        end
    end

    alu u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_result),
        .o_nzcv   (w_alu_nzcv)
    );

    assign bus.Done0  = (r_state == ST_RESP) && !r_grant;
    assign bus.Done1  = (r_state == ST_RESP) &&  r_grant;
    assign bus.Result = r_result;
    assign bus.NZCV   = r_nzcv;
    assign bus.Grant  = r_grant;
    assign bus.Busy   = (r_state != ST_IDLE);

endmodule
